// File: rtl/bpsk_pkg.sv
// Shared widths and the saturating-clamp helper for the BPSK Costas loop.
package bpsk_pkg;

  localparam int PD_W = 26;
  localparam int DF_W = 32;

  // Clamps a sign-extended value into the signed range of 'width' bits.
  // Callers pass a sum that is one bit wider than the target, so the clamp
  // replaces any wrap-around with the nearest representable extreme.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/costas_loop_filter_sat_add.sv
// Combinational signed adder with clamp to W bits and an overflow flag.
module sat_add
  import bpsk_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o,
  output logic                ovf_o
);

  logic signed [W:0]  sum;
  logic signed [63:0] wide;
  logic signed [63:0] clamped;

  // Add at W+1 bits so the true sum is always representable, then clamp.
  always_comb begin
    sum     = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    wide    = {{(64-W-1){sum[W]}}, sum};
    clamped = sat_trunc(wide, W);
    y_o     = clamped[W-1:0];
    ovf_o   = (clamped != wide);
  end

endmodule

// File: rtl/costas_loop_filter.sv
// PI loop filter for the BPSK Costas loop: integrate-and-dump of the phase
// error, then a shift-only proportional + integral update of the NCO word.
module costas_loop_filter
  import bpsk_pkg::*;
#(
  parameter int DECIM    = 8,
  parameter int KP_SHIFT = 6,
  parameter int KI_SHIFT = 14,
  parameter int OW       = DF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [PD_W-1:0] pd,
  input  logic                 hold,
  output logic signed [OW-1:0] df,
  output logic                 df_valid,
  output logic                 sat
);

  localparam int LG    = $clog2(DECIM);
  localparam int CNT_W = (LG > 0) ? LG : 1;
  localparam int AW    = PD_W + LG;
  localparam int EW    = (AW > OW) ? AW : OW;

  // Stage 0 state: running block sum and sample counter (cnt is the sequencer)
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]   pd_ext;
  logic signed [AW-1:0]   acc_sum;
  logic                   last;

  // Stage 0 -> 1 boundary
  logic signed [AW-1:0]   dump_p1, dump_d;
  logic                   vld_p1, vld_d;

  // Stage 1 state and results
  logic signed [OW-1:0]   integ_q, integ_d;
  logic signed [EW-1:0]   dump_ext;
  logic signed [EW-1:0]   p_ext;
  logic signed [EW-1:0]   i_ext;
  logic signed [OW-1:0]   p_val;
  logic signed [OW-1:0]   i_val;
  logic signed [OW-1:0]   integ_sum;
  logic signed [OW-1:0]   integ_n;
  logic signed [OW-1:0]   df_sum;
  logic                   int_ovf;
  logic                   out_ovf;

  // Stage 1 -> output boundary
  logic signed [OW-1:0]   df_q, df_d;
  logic                   vld_p2, vld_p2_d;
  logic                   sat_q, sat_d;

  // Integrate-and-dump: accumulate accepted samples, hand off every DECIM-th
  always_comb begin
    pd_ext  = AW'(pd);
    acc_sum = acc_q + pd_ext;
    last    = (cnt_q == CNT_W'(DECIM - 1));
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dump_d  = dump_p1;
    vld_d   = 1'b0;
    if (en) begin
      if (last) begin
        dump_d = acc_sum;
        vld_d  = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d  = acc_sum;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Floor shifts of the dump sum, sign-extended into the OW-bit datapath
  always_comb begin
    dump_ext = EW'(dump_p1);
    p_ext    = dump_ext >>> KP_SHIFT;
    i_ext    = dump_ext >>> KI_SHIFT;
    p_val    = p_ext[OW-1:0];
    i_val    = i_ext[OW-1:0];
  end

  sat_add #(.W(OW)) u_integ_add (
    .a_i   (integ_q),
    .b_i   (i_val),
    .y_o   (integ_sum),
    .ovf_o (int_ovf)
  );

  // hold freezes only the integral path; its clamp cannot fire while frozen
  always_comb begin
    integ_n = hold ? integ_q : integ_sum;
  end

  sat_add #(.W(OW)) u_out_add (
    .a_i   (p_val),
    .b_i   (integ_n),
    .y_o   (df_sum),
    .ovf_o (out_ovf)
  );

  // PI update on a dump; df holds between updates, pulses are one cycle
  always_comb begin
    integ_d  = integ_q;
    df_d     = df_q;
    vld_p2_d = vld_p1;
    sat_d    = 1'b0;
    if (vld_p1) begin
      integ_d = integ_n;
      df_d    = df_sum;
      sat_d   = (~hold & int_ovf) | out_ovf;
    end
  end

  // All pipeline state, cleared by active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      dump_p1 <= '0;
      vld_p1  <= 1'b0;
      integ_q <= '0;
      df_q    <= '0;
      vld_p2  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dump_p1 <= dump_d;
      vld_p1  <= vld_d;
      integ_q <= integ_d;
      df_q    <= df_d;
      vld_p2  <= vld_p2_d;
      sat_q   <= sat_d;
    end
  end

  assign df       = df_q;
  assign df_valid = vld_p2;
  assign sat      = sat_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Bench for costas_loop_filter: default instance plus a KI_SHIFT=0 instance
// sharing stimulus, checked against a plain-arithmetic reference model.
module tb_costas_loop_filter;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic hold;
  logic signed [25:0] pd;

  logic signed [31:0] df_a, df_b;
  logic dv_a, dv_b, sat_a, sat_b;

  int n_checks = 0;
  int n_fail   = 0;

  costas_loop_filter dut_a (
    .clk(clk), .rst(rst), .en(en), .pd(pd), .hold(hold),
    .df(df_a), .df_valid(dv_a), .sat(sat_a)
  );

  costas_loop_filter #(.KI_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pd(pd), .hold(hold),
    .df(df_b), .df_valid(dv_b), .sat(sat_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  longint m_sum[2], m_pendv[2], m_integ[2], m_df[2];
  int     m_n[2];
  bit     m_pend[2], m_dv[2], m_sat[2];
  int     ki[2] = '{14, 0};

  function automatic longint fdiv(input longint x, input int k);
    longint d, q;
    d = longint'(1) << k;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  task automatic model_edge(input logic r, input logic e,
                            input logic signed [25:0] p, input logic h);
    longint pv, iv, t, c;
    bit s;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_sum[k] = 0; m_n[k] = 0; m_pend[k] = 0; m_pendv[k] = 0;
        m_integ[k] = 0; m_df[k] = 0; m_dv[k] = 0; m_sat[k] = 0;
      end else begin
        m_dv[k] = 0; m_sat[k] = 0;
        if (m_pend[k]) begin
          pv = fdiv(m_pendv[k], 6);
          iv = fdiv(m_pendv[k], ki[k]);
          s  = 0;
          if (!h) begin
            t = m_integ[k] + iv; c = clamp32(t);
            if (c != t) s = 1;
            m_integ[k] = c;
          end
          t = pv + m_integ[k]; c = clamp32(t);
          if (c != t) s = 1;
          m_df[k] = c; m_dv[k] = 1; m_sat[k] = s;
        end
        m_pend[k] = 0;
        if (e) begin
          m_sum[k] += longint'(p);
          m_n[k]++;
          if (m_n[k] == 8) begin
            m_pend[k] = 1; m_pendv[k] = m_sum[k];
            m_sum[k] = 0; m_n[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic signed [25:0] p, input logic h);
    rst = r; en = e; pd = p; hold = h;
    @(posedge clk);
    model_edge(r, e, p, h);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int dvs;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 26'sd1000, 1'b0);
      n_checks++;
      if (df_a !== 32'sd0 || dv_a !== 1'b0 || sat_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got df=%0d v=%0b s=%0b want df=0 v=0 s=0",
                 c, df_a, dv_a, sat_a);
      end
    end
    dvs = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1, 26'sd1000, 1'b0);
      if (dv_a) dvs++;
    end
    n_checks++;
    if (dvs !== 0) begin
      n_fail++;
      $display("FAIL reset_early_valid: got %0d pulses want 0", dvs);
    end
    step(1'b1, 1'b0, 26'sd0, 1'b0);
    n_checks++;
    if (dv_a !== 1'b1 || df_a !== 32'sd125 || sat_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_update: got df=%0d v=%0b s=%0b want df=125 v=1 s=0",
               df_a, dv_a, sat_a);
    end
    // reset coincident with the block-completing sample suppresses the update
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    for (int c = 0; c < 7; c++) step(1'b1, 1'b1, 26'sd1000, 1'b0);
    step(1'b0, 1'b1, 26'sd1000, 1'b0);
    step(1'b1, 1'b0, 26'sd0, 1'b0);
    n_checks++;
    if (dv_a !== 1'b0 || df_a !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_vs_dump: got df=%0d v=%0b want df=0 v=0", df_a, dv_a);
    end
  endtask

  task automatic test_const_pos;
    int k;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0;
    for (int c = 0; c < 41; c++) begin
      step(1'b1, 1'b1, 26'sd4096, 1'b0);
      n_checks++;
      if (dv_a !== m_dv[0] || df_a !== 32'(m_df[0]) || sat_a !== m_sat[0]) begin
        n_fail++;
        $display("FAIL const_pos_model cycle %0d: got df=%0d v=%0b s=%0b want df=%0d v=%0b s=%0b",
                 c, df_a, dv_a, sat_a, m_df[0], m_dv[0], m_sat[0]);
      end
      if (dv_a) begin
        n_checks++;
        if (df_a !== 32'(514 + 2 * k) || sat_a !== 1'b0) begin
          n_fail++;
          $display("FAIL const_pos_value update %0d: got df=%0d s=%0b want df=%0d s=0",
                   k, df_a, sat_a, 514 + 2 * k);
        end
        k++;
      end
    end
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL const_pos_count: got %0d updates want 5", k);
    end
  endtask

  task automatic test_const_neg;
    int k;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0;
    for (int c = 0; c < 25; c++) begin
      step(1'b1, 1'b1, -26'sd1, 1'b0);
      if (dv_a) begin
        n_checks++;
        if (df_a !== 32'(-2 - k) || sat_a !== 1'b0) begin
          n_fail++;
          $display("FAIL const_neg update %0d: got df=%0d s=%0b want df=%0d s=0",
                   k, df_a, sat_a, -2 - k);
        end
        k++;
      end
    end
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL const_neg_count: got %0d updates want 3", k);
    end
  endtask

  task automatic test_en_alternate;
    int k, last_c;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0; last_c = -1;
    for (int c = 0; c < 66; c++) begin
      step(1'b1, (c % 2 == 0), 26'sd4096, 1'b0);
      if (dv_a) begin
        n_checks++;
        if (df_a !== 32'(514 + 2 * k)) begin
          n_fail++;
          $display("FAIL en_alt_value update %0d: got df=%0d want %0d", k, df_a, 514 + 2 * k);
        end
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c !== 16) begin
            n_fail++;
            $display("FAIL en_alt_spacing: got %0d cycles want 16", c - last_c);
          end
        end
        last_c = c; k++;
      end
    end
    n_checks++;
    if (k !== 4) begin
      n_fail++;
      $display("FAIL en_alt_count: got %0d updates want 4", k);
    end
  endtask

  task automatic test_saturation;
    int k;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0;
    for (int c = 0; c < 73; c++) begin
      step(1'b1, 1'b1, 26'sd33554431, 1'b0);
      n_checks++;
      if (dv_b !== m_dv[1] || df_b !== 32'(m_df[1]) || sat_b !== m_sat[1]) begin
        n_fail++;
        $display("FAIL sat_pos_model cycle %0d: got df=%0d v=%0b s=%0b want df=%0d v=%0b s=%0b",
                 c, df_b, dv_b, sat_b, m_df[1], m_dv[1], m_sat[1]);
      end
      if (dv_b) begin
        if (k == 0) begin
          n_checks++;
          if (df_b !== 32'sd272629751 || sat_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_pos_first: got df=%0d s=%0b want df=272629751 s=0", df_b, sat_b);
          end
        end
        if (k == 7 || k == 8) begin
          n_checks++;
          if (df_b !== 32'sd2147483647 || sat_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos_clamp update %0d: got df=%0d s=%0b want df=2147483647 s=1",
                     k + 1, df_b, sat_b);
          end
        end
        k++;
      end
    end
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0;
    for (int c = 0; c < 65; c++) begin
      step(1'b1, 1'b1, -26'sd33554432, 1'b0);
      if (dv_b) begin
        if (k == 7) begin
          n_checks++;
          if (df_b !== 32'sh8000_0000 || sat_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg_clamp: got df=%0d s=%0b want df=-2147483648 s=1", df_b, sat_b);
          end
        end
        k++;
      end
    end
  endtask

  task automatic test_hold_reset;
    int k, dvs;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    k = 0;
    for (int c = 0; c < 17; c++) begin
      step(1'b1, 1'b1, 26'sd4096, 1'b0);
      if (dv_a) k++;
    end
    n_checks++;
    if (k !== 2 || df_a !== 32'sd516) begin
      n_fail++;
      $display("FAIL hold_prefix: got %0d updates df=%0d want 2 updates df=516", k, df_a);
    end
    k = 0;
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 1'b1, 26'sd4096, 1'b1);
      if (dv_a) begin
        k++;
        n_checks++;
        if (df_a !== 32'sd516 || sat_a !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_value: got df=%0d s=%0b want df=516 s=0", df_a, sat_a);
        end
      end
    end
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL hold_count: got %0d updates want 3", k);
    end
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 26'sd4096, 1'b0);
    step(1'b0, 1'b1, 26'sd4096, 1'b0);
    dvs = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1, 26'sd4096, 1'b0);
      if (dv_a) dvs++;
    end
    step(1'b1, 1'b0, 26'sd0, 1'b0);
    n_checks++;
    if (dvs !== 0 || dv_a !== 1'b1 || df_a !== 32'sd514) begin
      n_fail++;
      $display("FAIL hold_after_reset: got early=%0d v=%0b df=%0d want early=0 v=1 df=514",
               dvs, dv_a, df_a);
    end
  endtask

  task automatic test_random;
    logic signed [25:0] rp;
    logic re, rh, rr;
    rh = 1'b0;
    step(1'b0, 1'b0, 26'sd0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0:       rp = 26'sd33554431;
        1:       rp = -26'sd33554432;
        default: rp = 26'($urandom);
      endcase
      re = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) rh = ~rh;
      rr = ($urandom_range(0, 499) != 0);
      step(rr, re, rp, rh);
      n_checks++;
      if (dv_a !== m_dv[0] || df_a !== 32'(m_df[0]) || sat_a !== m_sat[0]) begin
        n_fail++;
        $display("FAIL random_a cycle %0d: got df=%0d v=%0b s=%0b want df=%0d v=%0b s=%0b",
                 c, df_a, dv_a, sat_a, m_df[0], m_dv[0], m_sat[0]);
      end
      n_checks++;
      if (dv_b !== m_dv[1] || df_b !== 32'(m_df[1]) || sat_b !== m_sat[1]) begin
        n_fail++;
        $display("FAIL random_b cycle %0d: got df=%0d v=%0b s=%0b want df=%0d v=%0b s=%0b",
                 c, df_b, dv_b, sat_b, m_df[1], m_dv[1], m_sat[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; hold = 1'b0; pd = '0;
    test_reset();
    test_const_pos();
    test_const_neg();
    test_en_alternate();
    test_saturation();
    test_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/costas_loop_filter.md
Name: costas_loop_filter

Overview:
- Second-order proportional-integral (PI) loop filter for the BPSK Costas carrier-recovery loop.
- Sits directly downstream of the phase detector. It consumes the 26-bit signed phase-error sample stream `pd` at 8 MHz.
- Integrates and dumps `DECIM` samples, then produces a signed frequency-correction word `df` for the carrier NCO.
- The NCO adds `df` to its centre frequency. Filter gains are power-of-two shifts; there are no multipliers.

Parameters:
- DECIM, 8, number of pd samples summed per loop update; power of two, 1..256.
- KP_SHIFT, 6, proportional gain = 2^-KP_SHIFT applied to the dump sum.
- KI_SHIFT, 14, integral gain = 2^-KI_SHIFT applied to the dump sum.
- OW, 32, width of the integrator and of df.

Ports:
- clk  input  1  system clock, 8 MHz.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next clk edge).
- en  input  1  pd sample valid; the accumulator advances only when en=1.
- pd  input  26  signed phase-error sample from the phase detector.
- hold  input  1  freeze the integrator; the proportional path stays live.
- df  output  OW  signed frequency-correction word, registered.
- df_valid  output  1  one-cycle pulse when df updates.
- sat  output  1  one-cycle pulse, coincident with df_valid, when any clamp occurred in that update.

Behaviour:
- Reset (rst=0 at a clk edge) clears all of the following to 0: acc, cnt, dump, dump_v, integ, df, df_valid, sat.
  - Reset mid-accumulation discards the partial sum.
  - The first update after reset requires DECIM fresh accepted samples.
- Stage 0, integrate-and-dump:
  - acc is signed, 26+log2(DECIM) bits wide; cnt is log2(DECIM) bits wide.
  - On en=1 with cnt<DECIM-1: acc+=pd, cnt++.
  - On en=1 with cnt==DECIM-1: dump<=acc+pd, dump_v<=1, acc<=0, cnt<=0.
  - dump_v is otherwise 0.
  - With en=0, acc and cnt hold.
  - Full-scale pd cannot overflow acc.
- Stage 1, PI update (on dump_v=1):
  - p = dump>>>KP_SHIFT and i = dump>>>KI_SHIFT. Both are arithmetic shifts (floor), sign-extended to OW.
  - integ_n = sat(integ+i) when hold=0; integ_n = integ when hold=1. The register integ<=integ_n.
  - df<=sat(p+integ_n), df_valid<=1.
  - sat<=1 if either saturation clamped, else sat<=0.
  - When dump_v=0: df holds its value, df_valid=0, sat=0.
- sat() clamps to [-2^(OW-1), 2^(OW-1)-1]. Each sum is computed at OW+1 bits before the clamp, so there is no wrap-around anywhere.
- Latency: an en=1 cycle at edge T that completes a block gives df/df_valid visible after edge T+2.
  - Stage 1 completes even if en falls to 0.
  - Updates are spaced at least DECIM cycles apart, so there is no back-pressure.
- DECIM=1: every accepted sample dumps directly; the acc register is bypassed in effect.
- Simultaneous rst=0 and dump: reset wins, and no df_valid is issued.
- hold asserted mid-block takes effect at the next Stage 1 update only.
- There is no explicit FSM: cnt is the sequencer, and the dump_v/df_valid pipeline is 2 deep.

Decomposition:
- Package bpsk_pkg holds:
  - PD_W=26 and DF_W=32.
  - Function sat_trunc(value, width) for OW+1 to OW clamping.
- One sub-module, sat_add: a registered-free signed adder with clamp and overflow flag. It is instantiated twice, for the integrator and the output sum.

Test Plan:
1. Reset: rst=0 for 3 cycles while en=1, pd=1000 -> df=0, df_valid=0 throughout. After release, the first df_valid comes exactly 2 edges after the 8th accepted sample.
2. Constant pd=+4096, en=1, default parameters -> dump=32768, p=512, i=2. df=514, then 516, 518, ... with df_valid every 8 cycles and sat=0.
3. Constant pd=-1 -> dump=-8, p=-1, i=-1 (floor). df=-2, then -3, -4.
4. en alternating 1/0 with pd=4096 -> df_valid every 16 cycles; values identical to scenario 2.
5. KI_SHIFT=0 override, pd=33554431 constant -> dump=268435448, p=4194303.
   - Update 8: integ=2147483584 and df clamps to 2147483647 with sat=1.
   - Update 9: integ clamps to 2147483647, df=2147483647, sat=1.
   - Negative mirror (pd=-33554432): df clamps to -2147483648.
6. Scenario 2 with hold=1 after two updates -> df stays 516 (p=512, integ=4) on every update. With rst=0 pulsed after 5 samples of a block, the next df_valid needs 8 new samples and df=514.
